// File: rtl/alu_issue_seq_if.sv
// Command/result handshake bundle between the ALU issue sequencer and its
// upstream producer / downstream consumer.
interface alu_issue_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_opcode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [2:0]  out_flags;
    logic        out_err;

    modport slave (
        input  in_valid, in_a, in_b, in_opcode, out_ready,
        output in_ready, out_valid, out_result, out_flags, out_err
    );

    modport master (
        output in_valid, in_a, in_b, in_opcode, out_ready,
        input  in_ready, out_valid, out_result, out_flags, out_err
    );
endinterface

// File: rtl/alu_issue_seq.sv
// Command FIFO plus issue FSM feeding the IEEE754 ALU one command at a time.
// Optional ALU_SEQ_NAN_CHECK_EN: NaN operands bypass the ALU with a canonical qNaN.
//
// state | meaning
// IDLE  | nothing in flight, waiting for a queued command
// WAIT  | command driven on alu_*, counting down the ALU latency
// HOLD  | result presented on out_*, waiting for out_ready
module alu_issue_seq #(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    alu_issue_seq_if.slave         bus,
    output logic [31:0]            alu_a_o,
    output logic [31:0]            alu_b_o,
    output logic [4:0]             alu_opcode_o,
    input  logic [31:0]            alu_op_i,
    input  logic                   alu_gr_i,
    input  logic                   alu_lr_i,
    input  logic                   alu_eq_i,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  op;
    } cmd_t;

    cmd_t            mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q;
    logic            full, empty, push, pop;
    cmd_t            cmd_in, head;
    logic            head_legal, head_nan;

    state_t          state_q, state_d;
    logic [CW-1:0]   ctr_q, ctr_d;
    logic [31:0]     alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [4:0]      alu_opc_q, alu_opc_d;
    logic            out_valid_q, out_valid_d;
    logic [31:0]     out_result_q, out_result_d;
    logic [2:0]      out_flags_q, out_flags_d;
    logic            out_err_q, out_err_d;
    logic            issue;

    assign full   = (count_q == (AW+1)'(DEPTH));
    assign empty  = (count_q == '0);
    assign push   = bus.in_valid && !full;
    assign cmd_in = '{a: bus.in_a, b: bus.in_b, op: bus.in_opcode};
    assign head   = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= cmd_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Exactly one operation class; the sub modifier only rides on add.
    assign head_legal = $onehot(head.op[4:1]) && (!head.op[0] || head.op[1]);

`ifdef ALU_SEQ_NAN_CHECK_EN
    function automatic logic is_nan(input logic [31:0] f);
        return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
    endfunction
    assign head_nan = head_legal && (is_nan(head.a) || is_nan(head.b));
`else
    assign head_nan = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ctr_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_opc_q    <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_flags_q  <= '0;
            out_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ctr_q        <= ctr_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_opc_q    <= alu_opc_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_flags_q  <= out_flags_d;
            out_err_q    <= out_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ctr_d        = ctr_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_opc_d    = alu_opc_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_flags_d  = out_flags_q;
        out_err_d    = out_err_q;
        issue        = 1'b0;
        pop          = 1'b0;

        case (state_q)
            IDLE: issue = !empty;
            WAIT: begin
                if (ctr_q == '0) begin
                    out_result_d = alu_opc_q[2] ? 32'd0 : alu_op_i;
                    out_flags_d  = alu_opc_q[2] ? {alu_gr_i, alu_lr_i, alu_eq_i} : 3'b000;
                    out_err_d    = 1'b0;
                    out_valid_d  = 1'b1;
                    alu_opc_d    = '0;
                    state_d      = HOLD;
                end else begin
                    ctr_d = ctr_q - CW'(1);
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    if (!empty) begin
                        issue = 1'b1;
                    end else begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Popping a command either starts the ALU or, for bypassed commands,
        // produces the result on the same edge.
        if (issue) begin
            pop = 1'b1;
            if (!head_legal || head_nan) begin
                alu_opc_d    = '0;
                out_result_d = head_nan ? 32'h7FC0_0000 : 32'd0;
                out_flags_d  = 3'b000;
                out_err_d    = !head_legal;
                out_valid_d  = 1'b1;
                state_d      = HOLD;
            end else begin
                alu_a_d     = head.a;
                alu_b_d     = head.b;
                alu_opc_d   = head.op;
                ctr_d       = CW'(ALU_LAT - 1);
                out_valid_d = 1'b0;
                state_d     = WAIT;
            end
        end
    end

    assign alu_a_o        = alu_a_q;
    assign alu_b_o        = alu_b_q;
    assign alu_opcode_o   = alu_opc_q;
    assign count_o        = count_q;
    assign bus.in_ready   = !full;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_flags  = out_flags_q;
    assign bus.out_err    = out_err_q;
endmodule
